palette_color_mapper: RTL
=========================

// Module: palette_color_mapper
// PURPOSE
//  Final pixel stage between the sprite/background compositor and the VGA DAC.
//  Takes a per-pixel palette index plus raw sync and active-video signals, and
//  looks the index up in the 19-entry RGB palette table (palette[0:18][0:2], 8b/ch).
//  Applies full-screen effects: death flash, fade-to-black, hold-dark. Effects change
//  only on frame boundaries. Outputs registered RGB aligned with delayed sync/blank.
// PARAMETERS
//  N_COLORS      19  palette entries; index >= N_COLORS is illegal
//  IDX_W         5   palette index width
//  FLASH_IDX     14  palette entry shown on all active pixels during flash-on frames
//  FLASH_FRAMES  8   frames per flash half-period
//  FLASH_TOGGLES 6   flash half-periods before returning to NORMAL
//  FADE_FRAMES   4   frames per fade level (levels 0..7 = right shift 0..7)
// PORTS
//  Clk          in   1         pixel clock
//  Reset        in   1         synchronous, active-high
//  palette      in   19x3x8    RGB table from the palette block
//  pix_idx      in   IDX_W     palette index of the current pixel
//  pix_valid    in   1         1 = active video area
//  hs_in        in   1         hsync, active-low
//  vs_in        in   1         vsync, active-low
//  flash_req    in   1         1-cycle pulse: start death flash
//  fade_req     in   1         1-cycle pulse: start fade to black
//  restore_req  in   1         1-cycle pulse: return to NORMAL
//  VGA_R/G/B    out  8 each    registered colour
//  VGA_HS       out  1         hs_in delayed 2 cycles
//  VGA_VS       out  1         vs_in delayed 2 cycles
//  VGA_BLANK_N  out  1         pix_valid delayed 2 cycles
//  fx_busy      out  1         state != NORMAL
//  idx_err      out  1         sticky: illegal index seen while pix_valid
// BEHAVIOUR
//  - Reset (sync, high): RGB=0; HS=VS=1; BLANK_N=0; fx_busy=0; idx_err=0; FSM=NORMAL.
//    All counters and display snapshot regs go to 0. Reset mid-effect aborts the effect.
//  - Pipeline: S1 registers idx/valid/hs/vs. S2 does lookup + effect and registers outputs.
//    Latency is exactly 2 Clk for every output. No stalls; one pixel per clock.
//  - pix_valid=0 at S2 -> RGB=0 regardless of index or effect.
//  - idx >= N_COLORS with valid -> treat as entry 0 and set idx_err. idx_err clears only on Reset.
//  - frame_tick: 1-cycle pulse on the falling edge of vs_in (registered vs_in_d=1, vs_in=0).
//  - FSM states: NORMAL, FLASH, FADE, DARK. Request priority: restore > fade > flash.
//    NORMAL: flash_req -> FLASH (flash_on=1, toggle_cnt=0, frame_cnt=0).
//            fade_req -> FADE (level=0, frame_cnt=0).
//    FLASH: frame_cnt++ on each frame_tick. At FLASH_FRAMES-1: frame_cnt wraps to 0,
//           flash_on inverts, toggle_cnt++. toggle_cnt==FLASH_TOGGLES -> NORMAL.
//           fade_req aborts the flash -> FADE. flash_req is ignored.
//    FADE: level++ every FADE_FRAMES ticks. On the tick that would make level 8 -> DARK.
//          flash_req is ignored.
//    DARK: all active pixels are 0. Only restore_req leaves (-> NORMAL).
//    restore_req from any state -> NORMAL next cycle; counters cleared.
//  - A request coinciding with frame_tick: the transition takes effect and the new
//    counters start at 0. That tick is not counted.
//  - Display snapshot {mode, flash_on, level} is loaded from the FSM only on frame_tick.
//    Every visible frame is therefore uniform (no mid-frame tearing). fx_busy follows the
//    FSM immediately, not the snapshot.
//  - Colour per channel c: NORMAL -> pal[idx][c]; FLASH && flash_on -> pal[FLASH_IDX][c];
//    FADE -> pal[idx][c] >> level (logical shift, 8b); DARK -> 0.
// STRUCTURE
//  - frogger_video_pkg: N_COLORS, IDX_W, rgb_t (packed r,g,b 8b each), fx_state_e enum,
//    palette_t array typedef; shared with the palette block and the compositor.
//  - Sub-module fx_frame_ctrl: frame_tick detect, FSM, counters, snapshot regs.
//    The top level holds the 2-stage lookup/shift datapath and the sync delay line.
// TESTING
//  1 Reset held 3 clk during active video -> RGB=0, HS=VS=1, BLANK_N=0, fx_busy=0.
//  2 NORMAL, valid, idx=10 -> 2 clk later RGB=(250,0,0); idx=13 -> (0,80,250);
//    hs/vs pulses appear exactly 2 clk later.
//  3 idx=25 with valid -> RGB=(0,0,0), idx_err=1 and stays 1; with valid=0 -> no error.
//  4 flash_req mid-frame -> current frame unchanged, fx_busy=1 next clk. Next 8 frames:
//    active pixels (250,250,250); then 8 normal frames. After 6 half-periods -> NORMAL,
//    fx_busy=0.
//  5 fade_req, idx=14 -> frames show 250,125,62,31,... each level held 4 frames.
//    After level 7 -> DARK (RGB=0); restore_req -> next frame normal (250,250,250).
//  6 fade_req and flash_req same clk -> FADE; restore_req+fade_req same clk -> NORMAL;
//    Reset during FADE -> NORMAL, level 0.

Source files
------------

// File: rtl/frogger_video_pkg.sv
// Shared video types for the palette block, compositor and colour mapper.
package frogger_video_pkg;

   localparam int N_COLORS = 19;
   localparam int IDX_W    = 5;
   localparam int CH_W     = 8;
   localparam int LEVEL_W  = 3;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      FX_NORMAL = 2'd0,
      FX_FLASH  = 2'd1,
      FX_FADE   = 2'd2,
      FX_DARK   = 2'd3
   } fx_state_e;

   // Entry order is [index][channel], channel 0 = red, 1 = green, 2 = blue.
   typedef logic [0:N_COLORS-1][0:2][CH_W-1:0] palette_t;

   // Colour of one channel for the currently displayed effect.
   // Blanked pixels are always black; DARK blacks out the whole frame.
   function automatic logic [CH_W-1:0] fx_channel(
      input fx_state_e          mode,
      input logic               flash_on,
      input logic [LEVEL_W-1:0] level,
      input logic               valid,
      input logic [CH_W-1:0]    base_c,
      input logic [CH_W-1:0]    flash_c
   );
      logic [CH_W-1:0] c;
      c = '0;
      if (valid) begin
         case (mode)
            FX_FLASH:  c = flash_on ? flash_c : base_c;
            FX_FADE:   c = base_c >> level;
            FX_DARK:   c = '0;
            default:   c = base_c;
         endcase
      end
      return c;
   endfunction

   function automatic rgb_t to_rgb(input logic [0:2][CH_W-1:0] ch);
      rgb_t p;
      p.r = ch[0];
      p.g = ch[1];
      p.b = ch[2];
      return p;
   endfunction

endpackage

// File: rtl/fx_frame_ctrl.sv
// Full-screen effect controller: detects frame starts, runs the effect FSM
// and latches a per-frame snapshot so every visible frame is uniform.
module fx_frame_ctrl
   import frogger_video_pkg::*;
#(
   parameter int FLASH_FRAMES  = 8,
   parameter int FLASH_TOGGLES = 6,
   parameter int FADE_FRAMES   = 4
)
(
   input  logic               clk,
   input  logic               srst,
   input  logic               vs_in,
   input  logic               flash_req,
   input  logic               fade_req,
   input  logic               restore_req,
   output logic               fx_busy,
   output fx_state_e          disp_mode,
   output logic               disp_flash_on,
   output logic [LEVEL_W-1:0] disp_level
);

   localparam logic [2:0]         FLASH_LAST  = 3'(FLASH_FRAMES - 1);
   localparam logic [2:0]         TOGGLE_LAST = 3'(FLASH_TOGGLES - 1);
   localparam logic [2:0]         FADE_LAST   = 3'(FADE_FRAMES - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX   = '1;

   fx_state_e          state_reg, state_next;
   logic [2:0]         frame_cnt_reg, frame_cnt_next;
   logic [2:0]         toggle_cnt_reg, toggle_cnt_next;
   logic [LEVEL_W-1:0] level_reg, level_next;
   logic               flash_on_reg, flash_on_next;
   logic               vs_d_reg;
   logic               frame_tick;

   // Falling edge of vsync marks the start of a new frame.
   assign frame_tick = vs_d_reg & ~vs_in;

   // Effect state and counters.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg      <= FX_NORMAL;
         frame_cnt_reg  <= '0;
         toggle_cnt_reg <= '0;
         level_reg      <= '0;
         flash_on_reg   <= 1'b0;
         vs_d_reg       <= 1'b1;
      end else begin
         state_reg      <= state_next;
         frame_cnt_reg  <= frame_cnt_next;
         toggle_cnt_reg <= toggle_cnt_next;
         level_reg      <= level_next;
         flash_on_reg   <= flash_on_next;
         vs_d_reg       <= vs_in;
      end
   end

   // Next-state logic; a request wins over a coincident tick, which is then not counted.
   always_comb begin
      state_next      = state_reg;
      frame_cnt_next  = frame_cnt_reg;
      toggle_cnt_next = toggle_cnt_reg;
      level_next      = level_reg;
      flash_on_next   = flash_on_reg;
      if (restore_req) begin
         state_next      = FX_NORMAL;
         frame_cnt_next  = '0;
         toggle_cnt_next = '0;
         level_next      = '0;
         flash_on_next   = 1'b0;
      end else begin
         case (state_reg)
            FX_NORMAL: begin
               if (fade_req) begin
                  state_next     = FX_FADE;
                  frame_cnt_next = '0;
                  level_next     = '0;
               end else if (flash_req) begin
                  state_next      = FX_FLASH;
                  flash_on_next   = 1'b1;
                  toggle_cnt_next = '0;
                  frame_cnt_next  = '0;
               end
            end
            FX_FLASH: begin
               if (fade_req) begin
                  state_next      = FX_FADE;
                  frame_cnt_next  = '0;
                  toggle_cnt_next = '0;
                  level_next      = '0;
                  flash_on_next   = 1'b0;
               end else if (frame_tick) begin
                  if (frame_cnt_reg == FLASH_LAST) begin
                     frame_cnt_next = '0;
                     if (toggle_cnt_reg == TOGGLE_LAST) begin
                        state_next      = FX_NORMAL;
                        toggle_cnt_next = '0;
                        flash_on_next   = 1'b0;
                     end else begin
                        toggle_cnt_next = toggle_cnt_reg + 3'd1;
                        flash_on_next   = ~flash_on_reg;
                     end
                  end else begin
                     frame_cnt_next = frame_cnt_reg + 3'd1;
                  end
               end
            end
            FX_FADE: begin
               if (frame_tick) begin
                  if (frame_cnt_reg == FADE_LAST) begin
                     frame_cnt_next = '0;
                     if (level_reg == LEVEL_MAX) begin
                        state_next = FX_DARK;
                        level_next = '0;
                     end else begin
                        level_next = level_reg + 1'b1;
                     end
                  end else begin
                     frame_cnt_next = frame_cnt_reg + 3'd1;
                  end
               end
            end
            default: begin
               // DARK holds until restore_req.
            end
         endcase
      end
   end

   // Display snapshot, refreshed only at frame start to avoid mid-frame tearing.
   always_ff @(posedge clk) begin
      if (srst) begin
         disp_mode     <= FX_NORMAL;
         disp_flash_on <= 1'b0;
         disp_level    <= '0;
      end else if (frame_tick) begin
         disp_mode     <= state_reg;
         disp_flash_on <= flash_on_reg;
         disp_level    <= level_reg;
      end
   end

   assign fx_busy = (state_reg != FX_NORMAL);

endmodule

// File: rtl/palette_color_mapper.sv
// Final pixel stage: palette lookup plus full-screen effects, two-cycle
// pipeline with sync and blank delayed to stay aligned with the colour.
module palette_color_mapper
   import frogger_video_pkg::*;
#(
   parameter int FLASH_IDX     = 14,
   parameter int FLASH_FRAMES  = 8,
   parameter int FLASH_TOGGLES = 6,
   parameter int FADE_FRAMES   = 4
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  palette_t         palette,
   input  logic [IDX_W-1:0] pix_idx,
   input  logic             pix_valid,
   input  logic             hs_in,
   input  logic             vs_in,
   input  logic             flash_req,
   input  logic             fade_req,
   input  logic             restore_req,
   output logic [CH_W-1:0]  VGA_R,
   output logic [CH_W-1:0]  VGA_G,
   output logic [CH_W-1:0]  VGA_B,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             VGA_BLANK_N,
   output logic             fx_busy,
   output logic             idx_err
);

   logic [IDX_W-1:0]        idx_s1_reg;
   logic                    valid_s1_reg;
   logic                    hs_s1_reg;
   logic                    vs_s1_reg;

   fx_state_e               disp_mode;
   logic                    disp_flash_on;
   logic [LEVEL_W-1:0]      disp_level;

   logic                    idx_legal;
   logic [IDX_W-1:0]        eff_idx;
   logic [0:2][CH_W-1:0]    base_rgb;
   logic [0:2][CH_W-1:0]    flash_rgb;
   logic [CH_W-1:0]         chan_next [0:2];
   logic [0:2][CH_W-1:0]    rgb_reg;
   logic                    hs_reg;
   logic                    vs_reg;
   logic                    blank_n_reg;
   logic                    idx_err_reg;
   rgb_t                    out_rgb;

   // Stage 1: register the incoming pixel and sync.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx_s1_reg   <= '0;
         valid_s1_reg <= 1'b0;
         hs_s1_reg    <= 1'b1;
         vs_s1_reg    <= 1'b1;
      end else begin
         idx_s1_reg   <= pix_idx;
         valid_s1_reg <= pix_valid;
         hs_s1_reg    <= hs_in;
         vs_s1_reg    <= vs_in;
      end
   end

   fx_frame_ctrl #(
      .FLASH_FRAMES  (FLASH_FRAMES),
      .FLASH_TOGGLES (FLASH_TOGGLES),
      .FADE_FRAMES   (FADE_FRAMES)
   ) u_fx_ctrl (
      .clk           (Clk),
      .srst          (Reset),
      .vs_in         (vs_in),
      .flash_req     (flash_req),
      .fade_req      (fade_req),
      .restore_req   (restore_req),
      .fx_busy       (fx_busy),
      .disp_mode     (disp_mode),
      .disp_flash_on (disp_flash_on),
      .disp_level    (disp_level)
   );

   // Illegal indices fall back to entry 0.
   assign idx_legal = (idx_s1_reg < IDX_W'(N_COLORS));
   assign eff_idx   = idx_legal ? idx_s1_reg : '0;
   assign base_rgb  = palette[eff_idx];
   assign flash_rgb = palette[FLASH_IDX];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         assign chan_next[gi] = fx_channel(disp_mode, disp_flash_on, disp_level,
                                           valid_s1_reg, base_rgb[gi], flash_rgb[gi]);
      end
   endgenerate

   // Stage 2: register colour, delayed sync/blank and the sticky index error.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rgb_reg     <= '0;
         hs_reg      <= 1'b1;
         vs_reg      <= 1'b1;
         blank_n_reg <= 1'b0;
         idx_err_reg <= 1'b0;
      end else begin
         rgb_reg[0]  <= chan_next[0];
         rgb_reg[1]  <= chan_next[1];
         rgb_reg[2]  <= chan_next[2];
         hs_reg      <= hs_s1_reg;
         vs_reg      <= vs_s1_reg;
         blank_n_reg <= valid_s1_reg;
         idx_err_reg <= idx_err_reg | (valid_s1_reg & ~idx_legal);
      end
   end

   assign out_rgb     = to_rgb(rgb_reg);
   assign VGA_R       = out_rgb.r;
   assign VGA_G       = out_rgb.g;
   assign VGA_B       = out_rgb.b;
   assign VGA_HS      = hs_reg;
   assign VGA_VS      = vs_reg;
   assign VGA_BLANK_N = blank_n_reg;
   assign idx_err     = idx_err_reg;

endmodule
